// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a single shared 32-bit ADD/SUB/AND/OR ALU.
// Results are registered into a 1-deep response buffer tagged with the requester id.
module alu_share_arbiter #(
    parameter int WIDTH     = 32,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [2:0]       r0_ctrl,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [2:0]       r1_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             last_grant_r;
    logic             grant_valid_s;
    logic             grant_id_s;
    logic             can_accept_s;
    logic             accept_s;
    logic             rsp_valid_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [1:0]       sel_op_s;
    logic [WIDTH-1:0] alu_res_s;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             id_r;
    logic             unused_ctrl_s;

    // ctrl[2] carries no meaning for this ALU
    assign unused_ctrl_s = r0_ctrl[2] ^ r1_ctrl[2];

    function automatic logic [WIDTH-1:0] alu_compute(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] res;
        case (op)
            2'b00:   res = a + b;
            2'b01:   res = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
            2'b10:   res = a & b;
            2'b11:   res = a | b;
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    // Round-robin grant: a conflict goes to whoever did not win last time
    always_comb begin
        grant_valid_s = r0_valid | r1_valid;
        if (r0_valid && r1_valid) begin
            grant_id_s = ~last_grant_r;
        end else if (r1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // Operand mux and ALU evaluation for the granted requester
    always_comb begin
        if (grant_id_s) begin
            sel_a_s  = r1_a;
            sel_b_s  = r1_b;
            sel_op_s = r1_ctrl[1:0];
        end else begin
            sel_a_s  = r0_a;
            sel_b_s  = r0_b;
            sel_op_s = r0_ctrl[1:0];
        end
        alu_res_s = alu_compute(sel_a_s, sel_b_s, sel_op_s);
    end

    assign accept_s   = can_accept_s & grant_valid_s;
    assign r0_ready   = accept_s & ~grant_id_s;
    assign r1_ready   = accept_s & grant_id_s;
    assign rsp_valid  = rsp_valid_s;
    assign rsp_id     = id_r;
    assign rsp_result = result_r;
    assign rsp_zero   = zero_r;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: HOLD persists while the buffer is full or being refilled
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (rsp_ready && !accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: buffer occupancy and whether a new op may enter this cycle
    always_comb begin
        rsp_valid_s  = 1'b0;
        can_accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rsp_valid_s  = 1'b0;
                can_accept_s = 1'b1;
            end
            ST_HOLD: begin
                rsp_valid_s  = 1'b1;
                can_accept_s = rsp_ready;
            end
            default: begin
                rsp_valid_s  = 1'b0;
                can_accept_s = 1'b0;
            end
        endcase
    end

    // Response buffer and round-robin history, loaded only on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r     <= {WIDTH{1'b0}};
            zero_r       <= 1'b0;
            id_r         <= 1'b0;
            last_grant_r <= ~PRIO_INIT;
        end else if (accept_s) begin
            result_r     <= alu_res_s;
            zero_r       <= (alu_res_s == {WIDTH{1'b0}});
            id_r         <= grant_id_s;
            last_grant_r <= grant_id_s;
        end else begin
            result_r     <= result_r;
            zero_r       <= zero_r;
            id_r         <= id_r;
            last_grant_r <= last_grant_r;
        end
    end

endmodule
